// File: rtl/midi_voice_allocator.sv
// MIDI note-on/note-off parser with running status and a least-recently-allocated
// voice pool; publishes the most recent note-on for the note display.
module midi_voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int CHANNEL    = 0
) (
  input  logic                    CLK_I,
  input  logic                    RESET,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic [8*NUM_VOICES-1:0] voice_note,
  output logic [NUM_VOICES-1:0]   voice_trig,
  output logic [7:0]              NOTE
);

  localparam int RW = $clog2(NUM_VOICES);
  localparam logic [7:0] ST_OFF = 8'h80 | 8'(CHANNEL);
  localparam logic [7:0] ST_ON  = 8'h90 | 8'(CHANNEL);

  typedef enum logic [1:0] {WAIT_STATUS, DATA1, DATA2, IGNORE} state_t;

  state_t                state_q;
  logic                  on_q;
  logic [6:0]            data1_q;
  logic [NUM_VOICES-1:0] active_q;
  logic [NUM_VOICES-1:0] trig_q;
  logic [6:0]            note_q [NUM_VOICES];
  logic [RW-1:0]         rank_q [NUM_VOICES];
  logic [6:0]            last_q;

  logic          note_on_d;
  logic          hit_d;
  logic          free_d;
  logic [RW-1:0] hit_idx_d;
  logic [RW-1:0] free_idx_d;
  logic [RW-1:0] old_idx_d;
  logic [RW-1:0] target_d;

  // Scanning downward leaves the lowest matching index in each selector.
  always_comb begin
    note_on_d  = on_q && (rx_data[6:0] != 7'd0);
    hit_d      = 1'b0;
    free_d     = 1'b0;
    hit_idx_d  = '0;
    free_idx_d = '0;
    old_idx_d  = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (active_q[v] && (note_q[v] == data1_q)) begin
        hit_d     = 1'b1;
        hit_idx_d = RW'(v);
      end
      if (!active_q[v]) begin
        free_d     = 1'b1;
        free_idx_d = RW'(v);
      end
      if (rank_q[v] == RW'(NUM_VOICES - 1)) begin
        old_idx_d = RW'(v);
      end
    end
    if (hit_d) begin
      target_d = hit_idx_d;
    end else if (free_d) begin
      target_d = free_idx_d;
    end else begin
      target_d = old_idx_d;
    end
  end

  always_ff @(posedge CLK_I or posedge RESET) begin
    if (RESET) begin
      state_q  <= WAIT_STATUS;
      on_q     <= 1'b0;
      data1_q  <= '0;
      active_q <= '0;
      trig_q   <= '0;
      last_q   <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= '0;
        rank_q[v] <= RW'(v);
      end
    end else begin
      trig_q <= '0;
      // Real-time bytes (0xF8-0xFF) fall outside this branch and leave everything untouched.
      if (rx_valid && (rx_data < 8'hF8)) begin
        if (rx_data[7]) begin
          if ((rx_data == ST_ON) || (rx_data == ST_OFF)) begin
            on_q    <= rx_data[4];
            state_q <= DATA1;
          end else begin
            on_q    <= 1'b0;
            state_q <= IGNORE;
          end
        end else begin
          case (state_q)
            DATA1: begin
              data1_q <= rx_data[6:0];
              state_q <= DATA2;
            end
            DATA2: begin
              state_q <= DATA1;
              if (note_on_d) begin
                note_q[target_d]   <= data1_q;
                active_q[target_d] <= 1'b1;
                trig_q[target_d]   <= 1'b1;
                last_q             <= data1_q;
                for (int v = 0; v < NUM_VOICES; v++) begin
                  if (rank_q[v] < rank_q[target_d]) begin
                    rank_q[v] <= rank_q[v] + RW'(1);
                  end
                end
                rank_q[target_d] <= '0;
              end else if (hit_d) begin
                active_q[hit_idx_d] <= 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_note
      assign voice_note[8*gi +: 8] = {1'b0, note_q[gi]};
    end
  endgenerate

  assign voice_active = active_q;
  assign voice_trig   = trig_q;
  assign NOTE         = {1'b0, last_q};

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Bench for midi_voice_allocator: directed scenarios with literal expectations,
// then random byte streams compared every cycle against a queue-based voice model.
module tb_midi_voice_allocator;

  localparam int N  = 4;
  localparam int CH = 0;

  logic             clk;
  logic             rst;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [N-1:0]     voice_active;
  logic [8*N-1:0]   voice_note;
  logic [N-1:0]     voice_trig;
  logic [7:0]       note_out;

  midi_voice_allocator #(.NUM_VOICES(N), .CHANNEL(CH)) dut (
    .CLK_I       (clk),
    .RESET       (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .voice_active(voice_active),
    .voice_note  (voice_note),
    .voice_trig  (voice_trig),
    .NOTE        (note_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: parser phase, voice table, and an age list with the newest voice first.
  int       m_phase;          // 0 waiting, 1 expect note, 2 expect velocity, 3 ignoring
  bit       m_is_on;
  bit [6:0] m_d1;
  bit       m_active [N];
  bit [6:0] m_note   [N];
  bit [N-1:0] m_trig;
  bit [6:0] m_last;
  int       age [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    m_phase = 0; m_is_on = 0; m_d1 = 0; m_trig = 0; m_last = 0;
    age = {};
    for (int v = 0; v < N; v++) begin
      m_active[v] = 0; m_note[v] = 0; age.push_back(v);
    end
  endtask

  task automatic model_message(input bit [6:0] n, input bit [7:0] vel);
    int idx;
    idx = -1;
    if (m_is_on && vel != 0) begin
      for (int v = 0; v < N; v++) if (idx < 0 && m_active[v] && m_note[v] == n) idx = v;
      for (int v = 0; v < N; v++) if (idx < 0 && !m_active[v]) idx = v;
      if (idx < 0) idx = age[age.size()-1];
      m_note[idx] = n; m_active[idx] = 1; m_trig[idx] = 1'b1; m_last = n;
      for (int i = 0; i < age.size(); i++) begin
        if (age[i] == idx) begin
          age.delete(i);
          break;
        end
      end
      age.push_front(idx);
    end else begin
      for (int v = 0; v < N; v++) if (m_active[v] && m_note[v] == n) m_active[v] = 0;
    end
  endtask

  task automatic model_byte(input bit [7:0] d);
    if (d >= 8'hF8) begin
      // real-time: no effect
    end else if (d[7]) begin
      if (d == (8'h80 | CH) || d == (8'h90 | CH)) begin
        m_is_on = (d[7:4] == 4'h9); m_phase = 1;
      end else begin
        m_is_on = 0; m_phase = 3;
      end
    end else if (m_phase == 1) begin
      m_d1 = d[6:0]; m_phase = 2;
    end else if (m_phase == 2) begin
      model_message(m_d1, d); m_phase = 1;
    end
  endtask

  task automatic compare_all();
    logic [N-1:0]   ea;
    logic [8*N-1:0] en;
    for (int v = 0; v < N; v++) begin
      ea[v] = m_active[v];
      en[8*v +: 8] = {1'b0, m_note[v]};
    end
    chk("active", 64'(voice_active), 64'(ea));
    chk("note",   64'(voice_note),   64'(en));
    chk("trig",   64'(voice_trig),   64'(m_trig));
    chk("NOTE",   64'(note_out),     64'({1'b0, m_last}));
  endtask

  // Inputs change at the negedge; the model consumes the same byte on the posedge.
  task automatic cycle(input bit v, input bit [7:0] d);
    rx_valid = v; rx_data = d;
    @(posedge clk);
    m_trig = '0;
    if (!rst && v) model_byte(d);
    @(negedge clk);
    compare_all();
  endtask

  task automatic send(input bit [7:0] d);
    cycle(1'b1, d);
  endtask

  task automatic do_reset();
    rx_valid = 0; rx_data = 0;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_active", 64'(voice_active), 64'd0);
    chk("async_NOTE",   64'(note_out),     64'd0);
    repeat (2) cycle(1'b0, 8'h00);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_valid = 0; rx_data = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 8'h00);
    chk("reset_active", 64'(voice_active), 64'h0);
    chk("reset_note",   64'(voice_note),   64'h0);
    chk("reset_NOTE",   64'(note_out),     64'h0);

    // basic note
    send(8'h90); send(8'h3C); send(8'h64);
    chk("basic_active", 64'(voice_active), 64'h1);
    chk("basic_note",   64'(voice_note),   64'h0000003C);
    chk("basic_trig",   64'(voice_trig),   64'h1);
    chk("basic_NOTE",   64'(note_out),     64'h3C);
    cycle(1'b0, 8'h00);
    chk("basic_trig_clear", 64'(voice_trig), 64'h0);

    // running status, then note-off by velocity 0
    send(8'h40); send(8'h64);
    chk("rs_active", 64'(voice_active), 64'h3);
    chk("rs_note",   64'(voice_note),   64'h0000403C);
    send(8'h3C); send(8'h00);
    chk("off_active", 64'(voice_active), 64'h2);
    chk("off_NOTE",   64'(note_out),     64'h40);

    // stealing
    do_reset();
    send(8'h90);
    send(8'h3C); send(8'h64); send(8'h3E); send(8'h64);
    send(8'h40); send(8'h64); send(8'h41); send(8'h64);
    chk("fill_active", 64'(voice_active), 64'hF);
    chk("fill_note",   64'(voice_note),   64'h41403E3C);
    send(8'h43); send(8'h64);
    chk("steal_note", 64'(voice_note), 64'h41403E43);
    chk("steal_trig", 64'(voice_trig), 64'h1);
    send(8'h3E); send(8'h64);
    chk("retrig_note", 64'(voice_note), 64'h41403E43);
    chk("retrig_trig", 64'(voice_trig), 64'h2);
    send(8'h45); send(8'h64);
    chk("steal2_note", 64'(voice_note), 64'h41453E43);
    chk("steal2_trig", 64'(voice_trig), 64'h4);

    // real-time interleave
    do_reset();
    send(8'h90); send(8'hF8); send(8'h30); send(8'hFE); send(8'h50);
    chk("rt_active", 64'(voice_active), 64'h1);
    chk("rt_note",   64'(voice_note),   64'h00000030);

    // filtering
    send(8'h91); send(8'h31); send(8'h50);
    send(8'hB0); send(8'h07); send(8'h7F); send(8'h32); send(8'h50);
    chk("filt_active", 64'(voice_active), 64'h1);
    chk("filt_note",   64'(voice_note),   64'h00000030);
    chk("filt_NOTE",   64'(note_out),     64'h30);

    // reset mid-message
    send(8'h90); send(8'h3C);
    do_reset();
    send(8'h64);
    chk("midrst_active", 64'(voice_active), 64'h0);
    chk("midrst_NOTE",   64'(note_out),     64'h0);

    // random streams
    for (int i = 0; i < 4000; i++) begin
      int r;
      bit [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 10)      b = 8'h90 | CH;
      else if (r < 15) b = 8'h80 | CH;
      else if (r < 19) b = 8'(8'h80 + $urandom_range(0, 8'h77));
      else if (r < 23) b = 8'(8'hF8 + $urandom_range(0, 7));
      else if (r < 35) b = 8'h00;
      else             b = 8'(8'h3C + $urandom_range(0, 9));
      if ($urandom_range(0, 999) < 3) do_reset();
      else cycle($urandom_range(0, 9) < 7, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
